// File: rtl/edge_window_sequencer.sv
// Streaming 3x3 window builder and launch/wait/output sequencer for the Sobel engine.
// Two line buffers feed the window; one engine computation runs per complete window.
module edge_window_sequencer #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int TIMEOUT = 63
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_pix_valid,
  input  logic [7:0] i_pix,
  input  logic       i_sof,
  output logic       o_pix_ready,
  output logic       o_gradient_start,
  output logic [7:0] o_P0,
  output logic [7:0] o_P1,
  output logic [7:0] o_P2,
  output logic [7:0] o_P3,
  output logic [7:0] o_P4,
  output logic [7:0] o_P5,
  output logic [7:0] o_P6,
  output logic [7:0] o_P7,
  output logic [7:0] o_P8,
  input  logic       i_gradient_ready,
  input  logic [7:0] i_processed_sum,
  output logic       o_res_valid,
  output logic [7:0] o_res_data,
  output logic       o_res_last,
  input  logic       i_res_ready,
  output logic       o_timeout_err
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {FILL, LAUNCH, WAIT, OUTPUT, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [TW-1:0]   wd_q, wd_d;
  logic [8:0][7:0] win_q, win_d;
  logic            pix_ready_q, pix_ready_d;
  logic            start_q, start_d;
  logic            res_valid_q, res_valid_d;
  logic [7:0]      res_data_q, res_data_d;
  logic            res_last_q, res_last_d;
  logic            last_pend_q, last_pend_d;
  logic            err_q, err_d;

  // Line buffers hold no reset: rows 0/1 of every frame overwrite them before use.
  logic [7:0] lb_old_q [IMG_W];
  logic [7:0] lb_mid_q [IMG_W];

  logic          acc;
  logic [CW-1:0] pc;
  logic [RW-1:0] pr;

  assign acc = i_pix_valid && pix_ready_q;
  assign pc  = i_sof ? '0 : col_q;
  assign pr  = i_sof ? '0 : row_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    wd_d        = wd_q;
    win_d       = win_q;
    start_d     = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_last_d  = res_last_q;
    last_pend_d = last_pend_q;
    err_d       = err_q;

    if (acc) begin
      if (pc == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (pr == RW'(IMG_H - 1)) ? '0 : pr + 1'b1;
      end else begin
        col_d = pc + 1'b1;
        row_d = pr;
      end
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb_old_q[pc];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb_mid_q[pc];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = i_pix;
      if (i_sof) err_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (acc && pr >= RW'(2) && pc >= CW'(2)) begin
          state_d     = LAUNCH;
          start_d     = 1'b1;
          last_pend_d = (pr == RW'(IMG_H - 1)) && (pc == CW'(IMG_W - 1));
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (i_gradient_ready) begin
          res_data_d  = i_processed_sum;
          res_last_d  = last_pend_q;
          res_valid_d = 1'b1;
          state_d     = OUTPUT;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          // counter would reach TIMEOUT this cycle: engine is hung, emit a zero result
          err_d       = 1'b1;
          res_data_d  = 8'h00;
          res_last_d  = last_pend_q;
          res_valid_d = 1'b1;
          state_d     = OUTPUT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (i_res_ready) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (!i_gradient_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase

    pix_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      wd_q        <= '0;
      win_q       <= '0;
      pix_ready_q <= 1'b0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      res_last_q  <= 1'b0;
      last_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wd_q        <= wd_d;
      win_q       <= win_d;
      pix_ready_q <= pix_ready_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      last_pend_q <= last_pend_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      lb_old_q[pc] <= lb_mid_q[pc];
      lb_mid_q[pc] <= i_pix;
    end
  end

  assign o_pix_ready      = pix_ready_q;
  assign o_gradient_start = start_q;
  assign o_res_valid      = res_valid_q;
  assign o_res_data       = res_data_q;
  assign o_res_last       = res_last_q;
  assign o_timeout_err    = err_q;
  assign o_P0 = win_q[0];
  assign o_P1 = win_q[1];
  assign o_P2 = win_q[2];
  assign o_P3 = win_q[3];
  assign o_P4 = win_q[4];
  assign o_P5 = win_q[5];
  assign o_P6 = win_q[6];
  assign o_P7 = win_q[7];
  assign o_P8 = win_q[8];
endmodule

// File: tb/tb_edge_window_sequencer.sv
// Bench for edge_window_sequencer: behavioural Sobel engine plus a result scoreboard
// whose expectations come from the driven image, not from the DUT window.
module tb_edge_window_sequencer;
  localparam int W = 8, H = 8, TO = 63;

  logic clk = 1'b0, n_rst = 1'b0;
  logic i_pix_valid = 1'b0, i_sof = 1'b0, i_res_ready = 1'b1;
  logic [7:0] i_pix = 8'h00;
  logic i_gradient_ready;
  logic [7:0] i_processed_sum;
  logic o_pix_ready, o_gradient_start, o_res_valid, o_res_last, o_timeout_err;
  logic [7:0] o_res_data, o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7, o_P8;

  edge_window_sequencer #(.IMG_W(W), .IMG_H(H), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .i_pix_valid(i_pix_valid), .i_pix(i_pix), .i_sof(i_sof),
    .o_pix_ready(o_pix_ready), .o_gradient_start(o_gradient_start),
    .o_P0(o_P0), .o_P1(o_P1), .o_P2(o_P2), .o_P3(o_P3), .o_P4(o_P4),
    .o_P5(o_P5), .o_P6(o_P6), .o_P7(o_P7), .o_P8(o_P8),
    .i_gradient_ready(i_gradient_ready), .i_processed_sum(i_processed_sum),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_last(o_res_last),
    .i_res_ready(i_res_ready), .o_timeout_err(o_timeout_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0, n_fail = 0;
  logic [8:0] sbq[$];
  int img[H][W];
  int res_cnt = 0, last_cnt = 0, start_cnt = 0;
  int last_start_cyc = 0, first_start_cyc = 0, err_rise_cyc = 0, err_start_cyc = 0, acc18_cyc = 0;
  int eng_skip = 0;
  bit wd_zero_next = 1'b0, abort_drv = 1'b0;
  logic err_prev = 1'b0;

  function automatic int sob9(input int p0, input int p1, input int p2, input int p3,
                              input int p4, input int p5, input int p6, input int p7, input int p8);
    int gx, gy, s;
    gx = (p2 + 2*p5 + p8) - (p0 + 2*p3 + p6);
    gy = (p6 + 2*p7 + p8) - (p0 + 2*p1 + p2);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    s = gx + gy + 0*p4;
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int sob_img(input int r, input int c);
    return sob9(img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                img[r][c-2],   img[r][c-1],   img[r][c]);
  endfunction

  // Engine model: samples the window at launch, answers after a random latency
  // and holds ready for two cycles.
  initial begin
    int s;
    i_gradient_ready = 1'b0;
    i_processed_sum  = 8'h00;
    forever begin
      @(negedge clk);
      if (o_gradient_start && n_rst) begin
        if (eng_skip > 0) eng_skip--;
        else begin
          s = sob9(o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7, o_P8);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          i_gradient_ready = 1'b1;
          i_processed_sum  = 8'(s);
          repeat (2) @(negedge clk);
          i_gradient_ready = 1'b0;
          i_processed_sum  = 8'h00;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every result handshake.
  always begin
    logic [8:0] exp_v;
    @(negedge clk);
    #1;
    if (n_rst) begin
      if (o_gradient_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        if (first_start_cyc < 0) first_start_cyc = cyc;
      end
      if (o_timeout_err && !err_prev) begin
        err_rise_cyc  = cyc;
        err_start_cyc = last_start_cyc;
      end
      if (o_res_valid && i_res_ready) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got data=%0d last=%0b, expected no result", o_res_data, o_res_last);
        end else begin
          exp_v = sbq.pop_front();
          if ({o_res_last, o_res_data} !== exp_v) begin
            n_fail++;
            $display("FAIL sb_result#%0d: got data=%0d last=%0b, expected data=%0d last=%0b",
                     res_cnt, o_res_data, o_res_last, exp_v[7:0], exp_v[8]);
          end
        end
        res_cnt++;
        if (o_res_last) last_cnt++;
      end
    end
    err_prev = o_timeout_err;
  end

  task automatic drive_frame(input int npix);
    for (int k = 0; k < npix; k++) begin
      int r, c, wait_n;
      logic [7:0] d;
      if (abort_drv) break;
      r = k / W;
      c = k % W;
      wait_n = 0;
      if ($urandom_range(0, 3) == 0) begin
        i_pix_valid = 1'b0;
        @(negedge clk);
      end
      i_pix_valid = 1'b1;
      i_pix = 8'(img[r][c]);
      i_sof = (k == 0);
      while (!o_pix_ready && !abort_drv && wait_n < 400) begin
        @(negedge clk);
        wait_n++;
      end
      if (abort_drv) break;
      if (wait_n >= 400) begin
        n_tests++; n_fail++;
        $display("FAIL pix_ready_timeout: pixel %0d not accepted after %0d cycles, expected acceptance", k, wait_n);
        break;
      end
      if (k == 18) acc18_cyc = cyc;
      if (r >= 2 && c >= 2) begin
        d = wd_zero_next ? 8'h00 : 8'(sob_img(r, c));
        wd_zero_next = 1'b0;
        sbq.push_back({(r == H-1 && c == W-1), d});
      end
      @(negedge clk);
    end
    i_pix_valid = 1'b0;
    i_sof = 1'b0;
  endtask

  task automatic wait_results(input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (res_cnt >= n && sbq.size() == 0 && o_pix_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
  endtask

  task automatic check_frame(input string name);
    bit ok;
    wait_results(36, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s_done: got %0d results, %0d pending, expected 36 and 0", name, res_cnt, sbq.size()); end
    n_tests++;
    if (res_cnt !== 36) begin n_fail++; $display("FAIL %s_count: got %0d, expected 36", name, res_cnt); end
    n_tests++;
    if (last_cnt !== 1) begin n_fail++; $display("FAIL %s_last_cnt: got %0d, expected 1", name, last_cnt); end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({o_pix_ready, o_gradient_start, o_res_valid, o_res_data, o_res_last, o_timeout_err,
         o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7, o_P8} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs (pix_ready=%0b valid=%0b), expected all 0", o_pix_ready, o_res_valid);
    end
    n_rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0b, expected 1", o_pix_ready); end
  endtask

  task automatic test_uniform();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 100;
    res_cnt = 0; last_cnt = 0;
    drive_frame(64);
    check_frame("uniform");
    n_tests++;
    if (o_timeout_err !== 1'b0) begin n_fail++; $display("FAIL uniform_err: got %0b, expected 0", o_timeout_err); end
  endtask

  task automatic test_vertical_edge();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < 4) ? 0 : 200;
    res_cnt = 0; last_cnt = 0;
    drive_frame(64);
    check_frame("vedge");
  endtask

  task automatic test_backpressure();
    logic [9:0] held;
    int s0, wn;
    bit stable;
    fill_random();
    res_cnt = 0; last_cnt = 0;
    i_res_ready = 1'b0;
    fork
      drive_frame(64);
      begin
        wn = 0;
        while (!o_res_valid && wn < 300) begin @(negedge clk); wn++; end
        n_tests++;
        if (!o_res_valid) begin n_fail++; $display("FAIL bp_first_valid: got 0 after %0d cycles, expected 1", wn); end
        held = {o_res_valid, o_res_last, o_res_data};
        s0 = start_cnt;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if ({o_res_valid, o_res_last, o_res_data} !== held || o_pix_ready !== 1'b0) stable = 1'b0;
        end
        n_tests++;
        if (!stable) begin n_fail++; $display("FAIL bp_hold: got valid/last/data=%h pix_ready=%0b, expected %h and 0", {o_res_valid, o_res_last, o_res_data}, o_pix_ready, held); end
        n_tests++;
        if (start_cnt !== s0) begin n_fail++; $display("FAIL bp_extra_start: got %0d starts, expected %0d", start_cnt, s0); end
        i_res_ready = 1'b1;
      end
    join
    check_frame("bp");
  endtask

  task automatic test_watchdog();
    fill_random();
    res_cnt = 0; last_cnt = 0;
    err_rise_cyc = -1000;
    eng_skip = 1;
    wd_zero_next = 1'b1;
    drive_frame(64);
    check_frame("wd");
    n_tests++;
    if (err_rise_cyc - err_start_cyc !== 64) begin n_fail++; $display("FAIL wd_rise_delay: got %0d cycles, expected 64", err_rise_cyc - err_start_cyc); end
    n_tests++;
    if (o_timeout_err !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got %0b, expected 1", o_timeout_err); end
    drive_frame(1);
    n_tests++;
    if (o_timeout_err !== 1'b0) begin n_fail++; $display("FAIL wd_sof_clear: got %0b, expected 0", o_timeout_err); end
  endtask

  task automatic test_reset_in_wait();
    int s0, wn;
    fill_random();
    eng_skip = 1;
    abort_drv = 1'b0;
    s0 = start_cnt;
    fork
      drive_frame(64);
      begin
        wn = 0;
        while (start_cnt == s0 && wn < 300) begin @(negedge clk); wn++; end
        repeat (5) @(negedge clk);
        abort_drv = 1'b1;
        n_rst = 1'b0;
        #1;
        n_tests++;
        if ({o_pix_ready, o_gradient_start, o_res_valid, o_res_data, o_res_last, o_timeout_err,
             o_P0, o_P1, o_P2, o_P3, o_P4, o_P5, o_P6, o_P7, o_P8} !== '0) begin
          n_fail++; $display("FAIL rst_wait_outputs: got nonzero outputs (valid=%0b start=%0b), expected all 0", o_res_valid, o_gradient_start);
        end
      end
    join
    sbq.delete();
    eng_skip = 0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    abort_drv = 1'b0;
    @(negedge clk);
    fill_random();
    res_cnt = 0; last_cnt = 0;
    drive_frame(64);
    check_frame("rst_wait");
  endtask

  task automatic test_midframe_sof();
    fill_random();
    drive_frame(13);
    fill_random();
    res_cnt = 0; last_cnt = 0;
    first_start_cyc = -1;
    drive_frame(64);
    check_frame("midsof");
    n_tests++;
    if (first_start_cyc !== acc18_cyc + 1) begin n_fail++; $display("FAIL midsof_first_start: got cycle %0d, expected %0d", first_start_cyc, acc18_cyc + 1); end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_vertical_edge();
    test_backpressure();
    test_watchdog();
    test_reset_in_wait();
    test_midframe_sof();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1);
  end
endmodule
